// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store unit in front of a word-organised data memory.
// Handles byte/half/word loads (lane select + sign/zero extension) and
// stores (read-modify-write for sub-word stores), one request in flight.
// Optional macro LSU_MISALIGN_TRAP_EN: when defined, misaligned half/word
// accesses are trapped (rsp_err=1, no memory access); when undefined they
// are force-aligned and executed normally with rsp_err tied 0.
// Word-address width defaults to `DMEM_ADDRW when that macro is provided.

`ifndef DMEM_ADDRW
`define DMEM_ADDRW 10
`endif

module dmem_lsu #(
    parameter int ADDR_W = `DMEM_ADDRW,
    parameter int TAG_W  = 4
) (
    input  logic              i_clk,
    input  logic              i_resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_data,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              rsp_err,
    output logic              mem_valid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_MERGE, S_WR, S_RESP} state_t;

    state_t           state_q, state_d;
    logic [1:0]       lane_q;
    logic [1:0]       size_q;
    logic             uns_q;
    logic             we_q;
    logic [31:0]      wdata_q;
    logic [TAG_W-1:0] tag_q;
    logic [31:0]      rdata_q;
    logic             req_mis;
    logic             unused_addr;

    // Upper byte-address bits beyond the memory's reach are ignored.
    assign unused_addr = ^req_addr[31:ADDR_W+2];

    assign req_ready = (state_q == S_IDLE);

    // Misalignment detection: half needs addr[0]=0, word (size 2/3) needs addr[1:0]=0.
    always_comb begin
        req_mis = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        req_mis = ((req_size == 2'd1) && req_addr[0]) ||
                  (req_size[1] && (req_addr[1:0] != 2'b00));
`endif
    end

    // Select and extend the addressed lane of a read word.
    function automatic logic [31:0] load_ext(input logic [31:0] rd, input logic [1:0] a,
                                             input logic [1:0] sz, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = rd[{a, 3'b000} +: 8];
        h = rd[{a[1], 4'b0000} +: 16];
        case (sz)
            2'd0:    load_ext = uns ? {24'd0, b} : {{24{b[7]}}, b};
            2'd1:    load_ext = uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: load_ext = rd;
        endcase
    endfunction

    // Replace the addressed byte/half lane of the old word with store data.
    function automatic logic [31:0] merge_word(input logic [31:0] old, input logic [1:0] a,
                                               input logic [1:0] sz, input logic [31:0] wd);
        merge_word = old;
        case (sz)
            2'd0:    merge_word[{a, 3'b000} +: 8] = wd[7:0];
            2'd1:    merge_word[{a[1], 4'b0000} +: 16] = wd[15:0];
            default: merge_word = wd;
        endcase
    endfunction

    // State register.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) state_q <= S_IDLE;
        else           state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (req_mis)                      state_d = S_RESP;
                    else if (req_we && req_size[1])   state_d = S_WR;
                    else                              state_d = S_RD;
                end
            end
            S_RD:    if (mem_ready) state_d = we_q ? S_MERGE : S_RESP;
            S_MERGE: state_d = S_WR;
            S_WR:    if (mem_ready) state_d = S_RESP;
            S_RESP:  if (rsp_valid && rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Request latches and registered memory/response outputs.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            lane_q    <= '0;
            size_q    <= '0;
            uns_q     <= 1'b0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            tag_q     <= '0;
            rdata_q   <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_tag   <= '0;
            rsp_err   <= 1'b0;
            mem_valid <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        lane_q   <= req_addr[1:0];
                        size_q   <= req_size;
                        uns_q    <= req_unsigned;
                        we_q     <= req_we;
                        wdata_q  <= req_wdata;
                        tag_q    <= req_tag;
                        mem_addr <= req_addr[ADDR_W+1:2];
                        if (req_mis) begin
                            // Trapped: response fields now, rsp_valid one edge later.
                            rsp_data <= '0;
                            rsp_err  <= 1'b1;
                            rsp_tag  <= req_tag;
                        end else begin
                            mem_valid <= 1'b1;
                            mem_we    <= req_we && req_size[1];
                            if (req_we && req_size[1]) mem_wdata <= req_wdata;
                        end
                    end
                end
                S_RD: begin
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        if (we_q) begin
                            rdata_q <= mem_rdata;
                        end else begin
                            rsp_valid <= 1'b1;
                            rsp_data  <= load_ext(mem_rdata, lane_q, size_q, uns_q);
                            rsp_err   <= 1'b0;
                            rsp_tag   <= tag_q;
                        end
                    end
                end
                S_MERGE: begin
                    mem_wdata <= merge_word(rdata_q, lane_q, size_q, wdata_q);
                    mem_valid <= 1'b1;
                    mem_we    <= 1'b1;
                end
                S_WR: begin
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        mem_we    <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_data  <= '0;
                        rsp_err   <= 1'b0;
                        rsp_tag   <= tag_q;
                    end
                end
                S_RESP: begin
                    if (!rsp_valid)     rsp_valid <= 1'b1;
                    else if (rsp_ready) rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: directed checks of dmem_lsu against a one-cycle-ready memory.
module tb_dmem_lsu;

    localparam int AW = 10;
    localparam int TW = 4;

    logic          i_clk = 1'b0;
    logic          i_resetn = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [1:0]    req_size = 2'd0;
    logic          req_unsigned = 1'b0;
    logic [31:0]   req_addr = '0;
    logic [31:0]   req_wdata = '0;
    logic [TW-1:0] req_tag = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [31:0]   rsp_data;
    logic [TW-1:0] rsp_tag;
    logic          rsp_err;
    logic          mem_valid;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_ready = 1'b0;
    logic [31:0]   mem_rdata = '0;

    int checks = 0;
    int failures = 0;

    logic [31:0] mem [0:(1<<AW)-1];

    dmem_lsu #(.ADDR_W(AW), .TAG_W(TW)) dut (
        .i_clk(i_clk), .i_resetn(i_resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_tag(req_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_tag(rsp_tag), .rsp_err(rsp_err),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 i_clk = ~i_clk;

    // Memory: ready pulses one cycle after it sees valid; write/read happen then.
    always @(posedge i_clk) begin
        if (mem_ready) mem_ready <= 1'b0;
        else if (mem_valid) begin
            mem_ready <= 1'b1;
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr];
        end
    end

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One request: checks latency, mem_valid pattern, address, write data and response.
    task automatic do_req(input string nm, input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] tag,
                          input int hold, input int exp_lat, input logic [31:0] exp_data,
                          input logic exp_err, input logic [7:0] exp_mv,
                          input logic [31:0] exp_maddr, input logic [31:0] exp_wd);
        logic [7:0]  mv;
        logic [31:0] maddr;
        logic [31:0] wseen;
        int          lat;
        chk({nm, ".req_ready"}, req_ready, 1);
        req_we = we; req_size = sz; req_unsigned = uns; req_addr = addr;
        req_wdata = wd; req_tag = tag; req_valid = 1'b1;
        rsp_ready = (hold == 0);
        tick;
        req_valid = 1'b0;
        maddr = '1; wseen = '0; lat = 0;
        mv = {7'd0, mem_valid};
        if (mem_valid) maddr = 32'(mem_addr);
        while (!rsp_valid && lat < 20) begin
            tick;
            lat++;
            mv = {mv[6:0], mem_valid};
            if (mem_valid) maddr = 32'(mem_addr);
            if (mem_valid && mem_we) wseen = mem_wdata;
        end
        chk({nm, ".latency"}, lat, exp_lat);
        chk({nm, ".mem_valid_seq"}, mv, exp_mv);
        if (exp_mv != 8'd0) chk({nm, ".mem_addr"}, maddr, exp_maddr);
        if (we && exp_mv != 8'd0) chk({nm, ".mem_wdata"}, wseen, exp_wd);
        chk({nm, ".rsp_data"}, rsp_data, exp_data);
        chk({nm, ".rsp_tag"}, rsp_tag, tag);
        chk({nm, ".rsp_err"}, rsp_err, exp_err);
        for (int i = 0; i < hold; i++) begin
            tick;
            chk({nm, ".hold_valid"}, rsp_valid, 1);
            chk({nm, ".hold_data"}, rsp_data, exp_data);
            chk({nm, ".hold_tag"}, rsp_tag, tag);
            chk({nm, ".hold_req_ready"}, req_ready, 0);
        end
        rsp_ready = 1'b1;
        tick;
        chk({nm, ".rsp_cleared"}, rsp_valid, 0);
        chk({nm, ".idle_ready"}, req_ready, 1);
    endtask

    initial begin
        // Reset state
        tick; tick;
        chk("rst.req_ready", req_ready, 1);
        chk("rst.rsp_valid", rsp_valid, 0);
        chk("rst.mem_valid", mem_valid, 0);
        chk("rst.mem_we", mem_we, 0);
        chk("rst.rsp_data", rsp_data, 0);
        chk("rst.rsp_err", rsp_err, 0);
        i_resetn = 1'b1;
        tick;

        // Word store then load
        do_req("sw_dead", 1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 4'd1, 0, 2, 32'h0, 0,
               8'b110, 32'd4, 32'hDEADBEEF);
        do_req("lw_dead", 0, 2'd2, 0, 32'h10, 32'h0, 4'd2, 0, 2, 32'hDEADBEEF, 0,
               8'b110, 32'd4, 32'h0);

        // Byte read-modify-write
        do_req("sw_1122", 1, 2'd2, 0, 32'h10, 32'h11223344, 4'd3, 0, 2, 32'h0, 0,
               8'b110, 32'd4, 32'h11223344);
        do_req("sb_aa", 1, 2'd0, 0, 32'h12, 32'h000000AA, 4'd4, 0, 5, 32'h0, 0,
               8'b110110, 32'd4, 32'h11AA3344);
        do_req("lw_rmw", 0, 2'd2, 0, 32'h10, 32'h0, 4'd6, 0, 2, 32'h11AA3344, 0,
               8'b110, 32'd4, 32'h0);

        // Sign / zero extension
        do_req("sw_8000", 1, 2'd2, 0, 32'h10, 32'h800080FF, 4'd7, 0, 2, 32'h0, 0,
               8'b110, 32'd4, 32'h800080FF);
        do_req("lb_10", 0, 2'd0, 0, 32'h10, 32'h0, 4'd8, 0, 2, 32'hFFFFFFFF, 0,
               8'b110, 32'd4, 32'h0);
        do_req("lbu_10", 0, 2'd0, 1, 32'h10, 32'h0, 4'd9, 0, 2, 32'h000000FF, 0,
               8'b110, 32'd4, 32'h0);
        do_req("lh_12", 0, 2'd1, 0, 32'h12, 32'h0, 4'd10, 0, 2, 32'hFFFF8000, 0,
               8'b110, 32'd4, 32'h0);
        do_req("lhu_12", 0, 2'd1, 1, 32'h12, 32'h0, 4'd11, 0, 2, 32'h00008000, 0,
               8'b110, 32'd4, 32'h0);
        do_req("lb_11", 0, 2'd0, 0, 32'h11, 32'h0, 4'd12, 0, 2, 32'hFFFFFF80, 0,
               8'b110, 32'd4, 32'h0);

        // Back-pressure: response held for 4 cycles
        do_req("bp_lw", 0, 2'd2, 0, 32'h10, 32'h0, 4'd5, 4, 2, 32'h800080FF, 0,
               8'b110, 32'd4, 32'h0);

        // Misaligned accesses
`ifdef LSU_MISALIGN_TRAP_EN
        do_req("mis_lw", 0, 2'd2, 0, 32'h13, 32'h0, 4'd13, 0, 1, 32'h0, 1,
               8'b0, 32'd0, 32'h0);
        do_req("mis_lh", 0, 2'd1, 0, 32'h13, 32'h0, 4'd14, 0, 1, 32'h0, 1,
               8'b0, 32'd0, 32'h0);
`else
        do_req("mis_lw", 0, 2'd2, 0, 32'h13, 32'h0, 4'd13, 0, 2, 32'h800080FF, 0,
               8'b110, 32'd4, 32'h0);
        do_req("mis_lh", 0, 2'd1, 0, 32'h13, 32'h0, 4'd14, 0, 2, 32'hFFFF8000, 0,
               8'b110, 32'd4, 32'h0);
`endif

        // Halfword RMW into low lane
        do_req("sh_cafe", 1, 2'd1, 0, 32'h10, 32'h0000CAFE, 4'd15, 0, 5, 32'h0, 0,
               8'b110110, 32'd4, 32'h8000CAFE);
        do_req("lhu_cafe", 0, 2'd1, 1, 32'h10, 32'h0, 4'd0, 0, 2, 32'h0000CAFE, 0,
               8'b110, 32'd4, 32'h0);

        // Reset during the WR phase of a halfword store
        do_req("sw_pre", 1, 2'd2, 0, 32'h10, 32'h11223344, 4'd1, 0, 2, 32'h0, 0,
               8'b110, 32'd4, 32'h11223344);
        req_we = 1'b1; req_size = 2'd1; req_unsigned = 1'b0; req_addr = 32'h10;
        req_wdata = 32'h0000BEEF; req_tag = 4'd2; req_valid = 1'b1;
        tick;
        req_valid = 1'b0;
        tick; tick; tick;
        chk("rstwr.in_wr_valid", mem_valid, 1);
        chk("rstwr.in_wr_we", mem_we, 1);
        i_resetn = 1'b0;
        #1;
        chk("rstwr.mem_valid", mem_valid, 0);
        chk("rstwr.rsp_valid", rsp_valid, 0);
        tick;
        i_resetn = 1'b1;
        tick;
        chk("rstwr.req_ready", req_ready, 1);
        do_req("lw_after_rst", 0, 2'd2, 0, 32'h10, 32'h0, 4'd3, 0, 2, 32'h11223344, 0,
               8'b110, 32'd4, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
